// File: rtl/tdc_enable_regfile.sv
// Host-side channel-enable register with a notify/serve/ack handshake toward the TDC enable consumer.
// Optional master switch behaviour is enabled by defining TDC_ENABLE_MASTER_SWITCH_EN.
module tdc_enable_regfile #(
   parameter int CHANNEL_COUNT = 2,
   parameter int RETRY_CYCLES  = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        host_wr_en,
   input  logic        host_rd_en,
   input  logic [1:0]  host_addr,
   input  logic [31:0] host_wdata,
   output logic [31:0] host_rdata,
   output logic        host_rvalid,
   output logic        channel_changed,
   input  logic        read_active_channel,
   output logic        read_ack,
   output logic [16:0] activate_channels,
   output logic        pending
);

   localparam int TW = $clog2(RETRY_CYCLES);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(RETRY_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      NOTIFY,
      SERVE,
      ACK
   } state_t;

   state_t        state_q, state_d;
   logic [16:0]   enable_q, enable_d;
   logic [16:0]   shadow_q, shadow_d;
   logic          pending_q, pending_d;
   logic [TW-1:0] timeout_q, timeout_d;
   logic [7:0]    retry_q, retry_d;
   logic [31:0]   host_rdata_q, host_rdata_d;
   logic          host_rvalid_q, host_rvalid_d;
   logic          channel_changed_q, channel_changed_d;
   logic          read_ack_q, read_ack_d;
   logic          retry_inc;
   logic          wr_enable;
   logic          wr_command;
   logic [31:0]   status_word;
   logic          unused_wdata;

   assign unused_wdata = &{1'b0, host_wdata[31:17]};

   assign wr_enable   = host_wr_en && (host_addr == 2'd0);
   assign wr_command  = host_wr_en && (host_addr == 2'd2);
   assign status_word = {16'd0, retry_q, 6'd0, (state_q != IDLE), pending_q};

   // Handshake FSM plus register updates; host writes are applied last so a
   // write landing on the NOTIFY clear keeps pending set.
   always_comb begin
      state_d   = state_q;
      enable_d  = enable_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      timeout_d = timeout_q;
      retry_d   = retry_q;
      retry_inc = 1'b0;

      case (state_q)
         IDLE: begin
            if (pending_q) state_d = NOTIFY;
         end
         NOTIFY: begin
            shadow_d  = enable_q;
            pending_d = 1'b0;
            timeout_d = '0;
            state_d   = SERVE;
         end
         SERVE: begin
            if (read_active_channel) begin
               state_d = ACK;
            end else if (timeout_q == TIMEOUT_LAST) begin
               retry_inc = 1'b1;
               state_d   = NOTIFY;
            end else begin
               timeout_d = timeout_q + TW'(1);
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (wr_enable) begin
         enable_d  = host_wdata[16:0];
         pending_d = 1'b1;
      end
      if (wr_command && host_wdata[0]) pending_d = 1'b1;

      if (wr_command && host_wdata[1]) begin
         retry_d = 8'd0;
      end else if (retry_inc && (retry_q != 8'hFF)) begin
         retry_d = retry_q + 8'd1;
      end
   end

   // Registered host read port and handshake strobes; reads see pre-write values.
   always_comb begin
      host_rdata_d  = host_rdata_q;
      host_rvalid_d = host_rd_en;
      if (host_rd_en) begin
         case (host_addr)
            2'd0:    host_rdata_d = {15'd0, enable_q};
            2'd1:    host_rdata_d = status_word;
            default: host_rdata_d = 32'd0;
         endcase
      end
      channel_changed_d = (state_d == NOTIFY);
      read_ack_d        = (state_d == ACK);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q           <= IDLE;
         enable_q          <= '0;
         shadow_q          <= '0;
         pending_q         <= 1'b0;
         timeout_q         <= '0;
         retry_q           <= '0;
         host_rdata_q      <= '0;
         host_rvalid_q     <= 1'b0;
         channel_changed_q <= 1'b0;
         read_ack_q        <= 1'b0;
      end else begin
         state_q           <= state_d;
         enable_q          <= enable_d;
         shadow_q          <= shadow_d;
         pending_q         <= pending_d;
         timeout_q         <= timeout_d;
         retry_q           <= retry_d;
         host_rdata_q      <= host_rdata_d;
         host_rvalid_q     <= host_rvalid_d;
         channel_changed_q <= channel_changed_d;
         read_ack_q        <= read_ack_d;
      end
   end

`ifdef TDC_ENABLE_MASTER_SWITCH_EN
   localparam logic [16:0] CHANNEL_MASK = 17'((17'd1 << CHANNEL_COUNT) - 17'd1);
   assign activate_channels = shadow_q[16] ? (shadow_q | CHANNEL_MASK) : shadow_q;
`else
   assign activate_channels = shadow_q;
`endif

   assign host_rdata      = host_rdata_q;
   assign host_rvalid     = host_rvalid_q;
   assign channel_changed = channel_changed_q;
   assign read_ack        = read_ack_q;
   assign pending         = pending_q;

endmodule

// File: tb/tb_tdc_enable_regfile.sv
// Directed bench for tdc_enable_regfile (CHANNEL_COUNT=2, RETRY_CYCLES=8).
module tb_tdc_enable_regfile;

   logic        clk = 1'b0;
   logic        reset;
   logic        host_wr_en;
   logic        host_rd_en;
   logic [1:0]  host_addr;
   logic [31:0] host_wdata;
   logic [31:0] host_rdata;
   logic        host_rvalid;
   logic        channel_changed;
   logic        read_active_channel;
   logic        read_ack;
   logic [16:0] activate_channels;
   logic        pending;

   int tests_run    = 0;
   int tests_failed = 0;
   int pulse_count;

`ifdef TDC_ENABLE_MASTER_SWITCH_EN
   localparam logic [31:0] MASTER_EXPECT = 32'h10003;
`else
   localparam logic [31:0] MASTER_EXPECT = 32'h10000;
`endif

   tdc_enable_regfile #(
      .CHANNEL_COUNT(2),
      .RETRY_CYCLES (8)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .host_wr_en         (host_wr_en),
      .host_rd_en         (host_rd_en),
      .host_addr          (host_addr),
      .host_wdata         (host_wdata),
      .host_rdata         (host_rdata),
      .host_rvalid        (host_rvalid),
      .channel_changed    (channel_changed),
      .read_active_channel(read_active_channel),
      .read_ack           (read_ack),
      .activate_channels  (activate_channels),
      .pending            (pending)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic wr, input logic rd, input logic [1:0] addr,
                                input logic [31:0] wdata, input logic rac);
      host_wr_en          = wr;
      host_rd_en          = rd;
      host_addr           = addr;
      host_wdata          = wdata;
      read_active_channel = rac;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(0, 0, 2'd0, 32'd0, 0);
      tick();
      tick();
      reset = 1'b0;
      checkOutput("rst_rdata", host_rdata, 32'd0);
      checkOutput("rst_rvalid", 32'(host_rvalid), 32'd0);
      checkOutput("rst_changed", 32'(channel_changed), 32'd0);
      checkOutput("rst_ack", 32'(read_ack), 32'd0);
      checkOutput("rst_activate", 32'(activate_channels), 32'd0);
      checkOutput("rst_pending", 32'(pending), 32'd0);

      // Basic handshake: write 3 at t, consumer answers one cycle after notify.
      applyStimulus(1, 0, 2'd0, 32'h3, 0);
      tick();
      applyStimulus(0, 0, 2'd0, 32'd0, 0);
      checkOutput("basic_pending_t1", 32'(pending), 32'd1);
      checkOutput("basic_changed_t1", 32'(channel_changed), 32'd0);
      tick();
      checkOutput("basic_changed_t2", 32'(channel_changed), 32'd1);
      tick();
      checkOutput("basic_activate_t3", 32'(activate_channels), 32'h3);
      checkOutput("basic_ack_t3", 32'(read_ack), 32'd0);
      applyStimulus(0, 0, 2'd0, 32'd0, 1);
      tick();
      checkOutput("basic_ack_t4", 32'(read_ack), 32'd1);
      checkOutput("basic_activate_t4", 32'(activate_channels), 32'h3);
      applyStimulus(0, 0, 2'd0, 32'd0, 0);
      tick();
      checkOutput("basic_ack_t5", 32'(read_ack), 32'd0);
      checkOutput("basic_pending_t5", 32'(pending), 32'd0);

      // Silent consumer: notify re-pulses every 9 cycles, retry count climbs.
      applyStimulus(1, 0, 2'd0, 32'h5, 0);
      tick();
      applyStimulus(0, 0, 2'd0, 32'd0, 0);
      tick();
      checkOutput("retry_notify_t2", 32'(channel_changed), 32'd1);
      repeat (8) tick();
      checkOutput("retry_quiet_t10", 32'(channel_changed), 32'd0);
      tick();
      checkOutput("retry_notify_t11", 32'(channel_changed), 32'd1);
      repeat (9) tick();
      checkOutput("retry_notify_t20", 32'(channel_changed), 32'd1);
      repeat (9) tick();
      checkOutput("retry_notify_t29", 32'(channel_changed), 32'd1);
      applyStimulus(0, 1, 2'd1, 32'd0, 0);
      tick();
      checkOutput("retry_status3", host_rdata, 32'h0302);
      checkOutput("retry_status_valid", 32'(host_rvalid), 32'd1);
      applyStimulus(1, 0, 2'd2, 32'h2, 0);
      tick();
      applyStimulus(0, 1, 2'd1, 32'd0, 0);
      tick();
      checkOutput("retry_status_cleared", host_rdata, 32'h0002);
      applyStimulus(0, 0, 2'd0, 32'd0, 1);
      tick();
      checkOutput("retry_ack", 32'(read_ack), 32'd1);
      checkOutput("retry_activate", 32'(activate_channels), 32'h5);
      applyStimulus(0, 0, 2'd0, 32'd0, 0);
      tick();

      // Second write during SERVE is delivered by a follow-up notification.
      applyStimulus(1, 0, 2'd0, 32'h1, 0);
      tick();
      applyStimulus(0, 0, 2'd0, 32'd0, 0);
      tick();
      checkOutput("queue_notify1", 32'(channel_changed), 32'd1);
      tick();
      applyStimulus(1, 0, 2'd0, 32'h2, 0);
      tick();
      applyStimulus(0, 0, 2'd0, 32'd0, 1);
      checkOutput("queue_pending", 32'(pending), 32'd1);
      tick();
      checkOutput("queue_ack1", 32'(read_ack), 32'd1);
      checkOutput("queue_activate1", 32'(activate_channels), 32'h1);
      applyStimulus(0, 0, 2'd0, 32'd0, 0);
      tick();
      checkOutput("queue_ack1_drop", 32'(read_ack), 32'd0);
      tick();
      checkOutput("queue_notify2", 32'(channel_changed), 32'd1);
      tick();
      checkOutput("queue_activate2_pre", 32'(activate_channels), 32'h2);
      applyStimulus(0, 0, 2'd0, 32'd0, 1);
      tick();
      checkOutput("queue_ack2", 32'(read_ack), 32'd1);
      checkOutput("queue_activate2", 32'(activate_channels), 32'h2);
      applyStimulus(0, 0, 2'd0, 32'd0, 0);
      tick();
      checkOutput("queue_pending_done", 32'(pending), 32'd0);

      // Master switch bit.
      applyStimulus(1, 0, 2'd0, 32'h10000, 0);
      tick();
      applyStimulus(0, 0, 2'd0, 32'd0, 0);
      tick();
      checkOutput("master_notify", 32'(channel_changed), 32'd1);
      tick();
      applyStimulus(0, 0, 2'd0, 32'd0, 1);
      tick();
      checkOutput("master_ack", 32'(read_ack), 32'd1);
      checkOutput("master_activate", 32'(activate_channels), MASTER_EXPECT);
      applyStimulus(0, 0, 2'd0, 32'd0, 0);
      tick();

      // Reset landing on the ACK cycle drops everything.
      applyStimulus(1, 0, 2'd0, 32'h7, 0);
      tick();
      applyStimulus(0, 0, 2'd0, 32'd0, 0);
      tick();
      tick();
      applyStimulus(0, 0, 2'd0, 32'd0, 1);
      tick();
      checkOutput("rstack_ack_before", 32'(read_ack), 32'd1);
      reset = 1'b1;
      applyStimulus(0, 0, 2'd0, 32'd0, 0);
      tick();
      reset = 1'b0;
      checkOutput("rstack_ack", 32'(read_ack), 32'd0);
      checkOutput("rstack_activate", 32'(activate_channels), 32'd0);
      applyStimulus(0, 1, 2'd0, 32'd0, 0);
      tick();
      checkOutput("rstack_enable", host_rdata, 32'd0);
      applyStimulus(0, 0, 2'd0, 32'd0, 0);
      pulse_count = 0;
      for (int i = 0; i < 12; i++) begin
         if (channel_changed) pulse_count++;
         tick();
      end
      checkOutput("rstack_no_notify", 32'(pulse_count), 32'd0);
      checkOutput("rstack_pending", 32'(pending), 32'd0);

      // Same-cycle read and write returns the old value; reserved address reads 0.
      applyStimulus(1, 0, 2'd0, 32'h5, 0);
      tick();
      applyStimulus(1, 1, 2'd0, 32'hA, 0);
      tick();
      checkOutput("rw_old_value", host_rdata, 32'h5);
      checkOutput("rw_old_valid", 32'(host_rvalid), 32'd1);
      applyStimulus(0, 1, 2'd0, 32'd0, 0);
      tick();
      checkOutput("rw_new_value", host_rdata, 32'hA);
      applyStimulus(1, 0, 2'd3, 32'hFFFF_FFFF, 0);
      tick();
      applyStimulus(0, 1, 2'd3, 32'd0, 0);
      tick();
      checkOutput("rsvd_read", host_rdata, 32'd0);
      checkOutput("rsvd_valid", 32'(host_rvalid), 32'd1);
      applyStimulus(0, 1, 2'd0, 32'd0, 0);
      tick();
      checkOutput("rsvd_write_ignored", host_rdata, 32'hA);
      applyStimulus(0, 0, 2'd0, 32'd0, 0);
      tick();
      checkOutput("rvalid_drop", 32'(host_rvalid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/tdc_enable_regfile.md
# tdc_enable_regfile

Register-side responder for the TDC channel-enable handshake. Holds the host-written channel-enable register and signals each change to the channel-enable consumer with `channel_changed`. Answers the consumer's `read_active_channel` request with `read_ack` and a stable `activate_channels` word. Sits between the host register bus and the TDC channel-enable logic, one instance per TDC array.

## Interface
- `CHANNEL_COUNT`, 2: number of TDC channels (1..16); enable bits `[CHANNEL_COUNT-1:0]` are meaningful.
- `RETRY_CYCLES`, 64: cycles to wait in SERVE for `read_active_channel` before re-notifying; ≥4.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `host_wr_en`  in  1  host write strobe, one cycle per write.
- `host_rd_en`  in  1  host read strobe.
- `host_addr`  in  2  register address.
- `host_wdata`  in  32  write data.
- `host_rdata`  out  32  read data, registered.
- `host_rvalid`  out  1  read data valid pulse.
- `channel_changed`  out  1  one-cycle notify pulse to the consumer.
- `read_active_channel`  in  1  consumer read request, level.
- `read_ack`  out  1  one-cycle acknowledge; `activate_channels` is valid in this cycle.
- `activate_channels`  out  17  delivered enable word; bit 16 is the master switch.
- `pending`  out  1  a change has been written but not yet delivered.

## Operation
- Register map:
  - addr 0 ENABLE: R/W, bits [16:0], upper bits read 0.
  - addr 1 STATUS: RO. Bit 0 = `pending`, bit 1 = transaction in flight (state ≠ IDLE), bits [15:8] = retry count, saturating at 255.
  - addr 2 COMMAND: WO, reads 0. Writing bit 0 = 1 sets `pending` (force re-notify). Writing bit 1 = 1 clears the retry count.
  - addr 3: reserved. Writes are ignored; reads return 0.
- Any write to ENABLE sets `pending`, even when the value is unchanged.
- Host read: `host_rdata` and `host_rvalid` appear the cycle after `host_rd_en`. A simultaneous write and read to the same address returns the old value.
- FSM, states IDLE, NOTIFY, SERVE, ACK:
  - IDLE: if `pending`, go to NOTIFY.
  - NOTIFY (one cycle): assert `channel_changed`, load shadow ← ENABLE, clear `pending`, clear the timeout counter, go to SERVE.
  - SERVE: if `read_active_channel` = 1, go to ACK. Otherwise increment the timeout counter. When it reaches `RETRY_CYCLES`-1, increment the retry count and return to NOTIFY.
  - ACK (one cycle): assert `read_ack`, go to IDLE.
- `activate_channels` is driven continuously from the shadow register. It changes only in the cycle after NOTIFY, so it is stable through SERVE and ACK.
- Write arriving during NOTIFY, SERVE or ACK: sets `pending`; shadow is untouched. A new notification starts after returning to IDLE. A write in the same cycle as the NOTIFY clear wins, so `pending` stays 1.
- `read_active_channel` while in IDLE or NOTIFY is ignored; no `read_ack` is issued.

## Timing
- Reset values: `host_rdata`=0, `host_rvalid`=0, `channel_changed`=0, `read_ack`=0, `activate_channels`=0, `pending`=0. ENABLE=0, retry count=0, state IDLE.
- Reset mid-transaction aborts immediately. The notify or ack in flight is dropped, and nothing is re-sent after reset.
- Write to ENABLE at cycle t:
  - `pending`=1 at t+1.
  - `channel_changed` high during t+2 when the FSM was idle.
  - New `activate_channels` value visible at t+3.
- Consumer handshake: `read_active_channel` high in cycle n (sampled at the end of n) gives `read_ack` high in cycle n+1. The FSM is back in IDLE at n+2.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `TDC_ENABLE_MASTER_SWITCH_EN`:
  - Defined: when shadow bit 16 = 1, `activate_channels[CHANNEL_COUNT-1:0]` is forced to all ones. Bit 16 itself is still output as 1.
  - Undefined: `activate_channels` equals shadow bit-for-bit; bit 16 has no special meaning in this block.

## Test plan
- Reset, then write ENABLE=0x00003 at t, with a consumer model asserting `read_active_channel` one cycle after `channel_changed` → `channel_changed` at t+2; `read_ack` at t+4 with `activate_channels`=0x00003; `pending`=0 afterward.
- Consumer silent, `RETRY_CYCLES`=8, one ENABLE write → `channel_changed` re-pulses every 9 cycles; STATUS[15:8] increments to 3 after three timeouts; COMMAND bit 1 clears it to 0.
- Write ENABLE=0x1 then ENABLE=0x2 during SERVE → first `read_ack` delivers 0x1; second notify follows; second ack delivers 0x2.
- Write ENABLE=0x10000 with CHANNEL_COUNT=2 → `activate_channels`=0x10003 with the macro defined, 0x10000 without.
- Assert `reset` in the ACK cycle → next cycle `read_ack`=0, `activate_channels`=0, ENABLE reads 0, and no `channel_changed` follows.
- Read and write addr 0 in the same cycle (old value 0x5, new value 0xA) → `host_rdata`=0x5 with `host_rvalid`; the next read returns 0xA. Reads of addr 3 return 0.
